// File: rtl/riscv_bypass_scoreboard.sv
// Operand bypass network with long-latency busy scoreboard and stall counter.
// Ports: per-port rs/rf in, per-stage wr/addr/data in, lat issue/cmpl in; op_data/op_fwd_sel/stall/busy_vec/stall_cnt out.
module riscv_bypass_scoreboard #(
    parameter int XLEN           = 32,
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_FWD_STAGES = 3,
    parameter int CNT_W          = 32,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD_PORTS-1:0]          rd_valid,
    input  logic [NUM_RD_PORTS*5-1:0]        rs_addr,
    input  logic [NUM_RD_PORTS*XLEN-1:0]     rf_data,
    input  logic [NUM_FWD_STAGES-1:0]        stg_wr_en,
    input  logic [NUM_FWD_STAGES*5-1:0]      stg_rd_addr,
    input  logic [NUM_FWD_STAGES*XLEN-1:0]   stg_data,
    input  logic [NUM_FWD_STAGES-1:0]        stg_data_vld,
    input  logic                             lat_issue_vld,
    input  logic [4:0]                       lat_issue_rd,
    input  logic                             lat_cmpl_vld,
    input  logic [4:0]                       lat_cmpl_rd,
    output logic [NUM_RD_PORTS*XLEN-1:0]     op_data,
    output logic [NUM_RD_PORTS*SEL_W-1:0]    op_fwd_sel,
    output logic                             stall,
    output logic [31:0]                      busy_vec,
    output logic [CNT_W-1:0]                 stall_cnt
);

    logic [31:0]             busy_q;
    logic [31:0]             busy_d;
    logic [31:0]             busy_use;
    logic [NUM_RD_PORTS-1:0] port_haz;
    logic                    waw;

    // While reset is held the tracked state is already meaningless.
    assign busy_use = rst_n ? busy_q : '0;
    assign busy_vec = busy_q;

    always_comb begin
        op_data    = '0;
        op_fwd_sel = '0;
        port_haz   = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            logic [4:0]      rs;
            logic            hit;
            logic            hit_vld;
            logic [SEL_W-1:0] sel;
            logic [XLEN-1:0] data;
            rs      = rs_addr[p*5 +: 5];
            hit     = 1'b0;
            hit_vld = 1'b1;
            sel     = '0;
            data    = rf_data[p*XLEN +: XLEN];
            // Scan oldest to youngest so the youngest match is left standing.
            // A pending load wins anyway; the port must not skip past it.
            for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
                if (stg_wr_en[s] && (stg_rd_addr[s*5 +: 5] != 5'd0) &&
                    (stg_rd_addr[s*5 +: 5] == rs)) begin
                    hit     = 1'b1;
                    hit_vld = stg_data_vld[s];
                    sel     = SEL_W'(s + 1);
                    data    = stg_data[s*XLEN +: XLEN];
                end
            end
            if (rs == 5'd0) begin
                data = '0;
            end
            op_data[p*XLEN +: XLEN]     = data;
            op_fwd_sel[p*SEL_W +: SEL_W] = sel;
            // A stage match overrides busy, so the completion cycle bypasses.
            port_haz[p] = rd_valid[p] && (hit ? !hit_vld : busy_use[rs]);
        end
    end

    assign waw   = lat_issue_vld && (lat_issue_rd != 5'd0) &&
                   busy_use[lat_issue_rd];
    assign stall = (|port_haz) || waw;

    // Clear is applied after set so a same-register collision resolves clear.
    always_comb begin
        busy_d = busy_q;
        if (lat_issue_vld && !stall && (lat_issue_rd != 5'd0)) begin
            busy_d[lat_issue_rd] = 1'b1;
        end
        if (lat_cmpl_vld) begin
            busy_d[lat_cmpl_rd] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            stall_cnt <= '0;
        end else begin
            busy_q <= busy_d;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_bypass_scoreboard.sv
// Self-checking bench for riscv_bypass_scoreboard (CNT_W = 4 build).
// Expected values queued on stimulus, popped and compared after settle.
module tb_riscv_bypass_scoreboard;

    localparam int XLEN  = 32;
    localparam int NRP   = 2;
    localparam int NFS   = 3;
    localparam int CNT_W = 4;
    localparam int SEL_W = 2;

    localparam int K_SEL0  = 0;
    localparam int K_SEL1  = 1;
    localparam int K_D0    = 2;
    localparam int K_D1    = 3;
    localparam int K_STALL = 4;
    localparam int K_BUSY  = 5;
    localparam int K_CNT   = 6;

    logic                  clk;
    logic                  rst_n;
    logic [NRP-1:0]        rd_valid;
    logic [NRP*5-1:0]      rs_addr;
    logic [NRP*XLEN-1:0]   rf_data;
    logic [NFS-1:0]        stg_wr_en;
    logic [NFS*5-1:0]      stg_rd_addr;
    logic [NFS*XLEN-1:0]   stg_data;
    logic [NFS-1:0]        stg_data_vld;
    logic                  lat_issue_vld;
    logic [4:0]            lat_issue_rd;
    logic                  lat_cmpl_vld;
    logic [4:0]            lat_cmpl_rd;
    logic [NRP*XLEN-1:0]   op_data;
    logic [NRP*SEL_W-1:0]  op_fwd_sel;
    logic                  stall;
    logic [31:0]           busy_vec;
    logic [CNT_W-1:0]      stall_cnt;

    riscv_bypass_scoreboard #(
        .XLEN(XLEN), .NUM_RD_PORTS(NRP),
        .NUM_FWD_STAGES(NFS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rs_addr(rs_addr), .rf_data(rf_data),
        .stg_wr_en(stg_wr_en), .stg_rd_addr(stg_rd_addr),
        .stg_data(stg_data), .stg_data_vld(stg_data_vld),
        .lat_issue_vld(lat_issue_vld), .lat_issue_rd(lat_issue_rd),
        .lat_cmpl_vld(lat_cmpl_vld), .lat_cmpl_rd(lat_cmpl_rd),
        .op_data(op_data), .op_fwd_sel(op_fwd_sel), .stall(stall),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic       stall_m = 1'b0;
    logic [3:0] cnt_m = 4'd0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_SEL0:  return 64'(op_fwd_sel[0 +: SEL_W]);
            K_SEL1:  return 64'(op_fwd_sel[SEL_W +: SEL_W]);
            K_D0:    return 64'(op_data[0 +: XLEN]);
            K_D1:    return 64'(op_data[XLEN +: XLEN]);
            K_STALL: return 64'(stall);
            K_BUSY:  return 64'(busy_vec);
            default: return 64'(stall_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int kind,
                        input logic [63:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        q.push_back(e);
        if (kind == K_STALL) stall_m = exp[0];
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, observe(e.kind), e.exp);
        end
    endtask

    // Advance one edge, update the counter reference, land on negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) cnt_m = 4'd0;
        else if (stall_m && cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
        @(negedge clk);
    endtask

    task automatic idle();
        rd_valid      = '0;
        rs_addr       = '0;
        rf_data       = '0;
        stg_wr_en     = '0;
        stg_rd_addr   = '0;
        stg_data      = '0;
        stg_data_vld  = '1;
        lat_issue_vld = 1'b0;
        lat_issue_rd  = '0;
        lat_cmpl_vld  = 1'b0;
        lat_cmpl_rd   = '0;
        stall_m       = 1'b0;
    endtask

    task automatic set_stg(input int s, input logic [4:0] a,
                           input logic [31:0] d, input logic v);
        stg_wr_en[s]           = 1'b1;
        stg_rd_addr[s*5 +: 5]  = a;
        stg_data[s*XLEN +: XLEN] = d;
        stg_data_vld[s]        = v;
    endtask

    task automatic set_rd(input int p, input logic v, input logic [4:0] a,
                          input logic [31:0] rf);
        rd_valid[p]             = v;
        rs_addr[p*5 +: 5]       = a;
        rf_data[p*XLEN +: XLEN] = rf;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        push("rst_busy", K_BUSY, 64'd0);
        push("rst_cnt", K_CNT, 64'd0);
        push("rst_stall", K_STALL, 64'd0);
        drain();

        // T1: youngest match wins
        set_stg(0, 5'd5, 32'hAAAA, 1'b1);
        set_stg(2, 5'd5, 32'hBBBB, 1'b1);
        set_stg(1, 5'd6, 32'h6666, 1'b1);
        set_rd(0, 1'b1, 5'd5, 32'h1111);
        set_rd(1, 1'b1, 5'd6, 32'h2222);
        push("t1_sel0", K_SEL0, 64'd1);
        push("t1_d0", K_D0, 64'hAAAA);
        push("t1_sel1", K_SEL1, 64'd2);
        push("t1_d1", K_D1, 64'h6666);
        push("t1_stall", K_STALL, 64'd0);
        drain();
        stg_wr_en[0] = 1'b0;
        push("t1_old_sel", K_SEL0, 64'd3);
        push("t1_old_d", K_D0, 64'hBBBB);
        drain();
        stg_wr_en = '0;
        push("t1_rf_sel", K_SEL0, 64'd0);
        push("t1_rf_d", K_D0, 64'h1111);
        push("t1_rf_d1", K_D1, 64'h2222);
        drain();
        tick();

        // T2: pending load does not fall through
        idle();
        set_stg(0, 5'd7, 32'h7070, 1'b0);
        set_stg(1, 5'd7, 32'h7171, 1'b1);
        set_rd(1, 1'b1, 5'd7, 32'h0);
        push("t2_sel", K_SEL1, 64'd1);
        push("t2_stall", K_STALL, 64'd1);
        drain();
        tick();
        rd_valid[1] = 1'b0;
        push("t2_nv_stall", K_STALL, 64'd0);
        push("t2_nv_sel", K_SEL1, 64'd1);
        push("t2_cnt", K_CNT, 64'(cnt_m));
        drain();
        tick();

        // T3: long op RAW stalls until bypassed completion
        idle();
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd9;
        push("t3_iss_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        set_rd(0, 1'b1, 5'd9, 32'h5);
        for (int i = 0; i < 2; i++) begin
            push("t3_busy", K_BUSY, 64'h200);
            push("t3_stall", K_STALL, 64'd1);
            drain();
            tick();
        end
        lat_cmpl_vld = 1'b1;
        lat_cmpl_rd  = 5'd9;
        set_stg(1, 5'd9, 32'h9999, 1'b1);
        push("t3_cmp_sel", K_SEL0, 64'd2);
        push("t3_cmp_d", K_D0, 64'h9999);
        push("t3_cmp_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        push("t3_busy_clr", K_BUSY, 64'd0);
        push("t3_cnt", K_CNT, 64'(cnt_m));
        drain();

        // T4: WAW stall, unbypassed completion, reissue, mixed set/clear
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd3;
        push("t4_iss_stall", K_STALL, 64'd0);
        drain();
        tick();
        push("t4_waw_stall", K_STALL, 64'd1);
        drain();
        tick();
        idle();
        push("t4_busy_hold", K_BUSY, 64'h8);
        lat_cmpl_vld = 1'b1;
        lat_cmpl_rd  = 5'd3;
        set_rd(0, 1'b1, 5'd3, 32'h0);
        push("t4_clr_stall", K_STALL, 64'd1);
        drain();
        tick();
        idle();
        push("t4_busy_clr", K_BUSY, 64'd0);
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd3;
        push("t4_re_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        push("t4_reissue", K_BUSY, 64'h8);
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd4;
        lat_cmpl_vld  = 1'b1;
        lat_cmpl_rd   = 5'd3;
        push("t4_mix_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        push("t4_mix_busy", K_BUSY, 64'h10);
        lat_cmpl_vld = 1'b1;
        lat_cmpl_rd  = 5'd4;
        drain();
        tick();
        idle();
        push("t4_end_busy", K_BUSY, 64'd0);
        drain();

        // T5: x0 never matches, never stalls, never goes busy
        set_stg(0, 5'd0, 32'hDEAD, 1'b0);
        set_stg(1, 5'd0, 32'hBEEF, 1'b1);
        set_stg(2, 5'd0, 32'hCAFE, 1'b1);
        set_rd(0, 1'b1, 5'd0, 32'h1234);
        set_rd(1, 1'b1, 5'd0, 32'h1234);
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd0;
        push("t5_d0", K_D0, 64'd0);
        push("t5_sel0", K_SEL0, 64'd0);
        push("t5_d1", K_D1, 64'd0);
        push("t5_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        push("t5_busy", K_BUSY, 64'd0);
        drain();

        // T6: saturate counter, then reset mid-stall
        lat_issue_vld = 1'b1;
        lat_issue_rd  = 5'd12;
        push("t6_iss_stall", K_STALL, 64'd0);
        drain();
        tick();
        idle();
        set_stg(0, 5'd7, 32'h0, 1'b0);
        set_rd(1, 1'b1, 5'd7, 32'h0);
        for (int i = 0; i < 20 && cnt_m != 4'hE; i++) begin
            push("t6_pre_stall", K_STALL, 64'd1);
            drain();
            tick();
        end
        push("t6_pre_cnt", K_CNT, 64'hE);
        drain();
        for (int i = 0; i < 3; i++) begin
            push("t6_sat_stall", K_STALL, 64'd1);
            drain();
            tick();
            push("t6_sat_cnt", K_CNT, 64'hF);
            drain();
        end
        push("t6_busy_pre", K_BUSY, 64'h1000);
        drain();
        rst_n = 1'b0;
        push("t6_rst_stall", K_STALL, 64'd1);
        drain();
        tick();
        push("t6_rst_busy", K_BUSY, 64'd0);
        push("t6_rst_cnt", K_CNT, 64'd0);
        drain();
        rst_n = 1'b1;
        idle();
        tick();
        push("t6_post_cnt", K_CNT, 64'(cnt_m));
        push("t6_post_busy", K_BUSY, 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
